// File: rtl/ama_riscv_reg_dump_if.sv
// ama_riscv_reg_dump_if
// Bundles the register-dump engine's control, register-file read port and
// streaming output into one interface.
//   master : the dump engine (drives rf_addr, stream outputs, busy/stall/done)
//   slave  : the surrounding core/debug unit (drives req/abort, rf_data, ready)
// Signals:
//   dump_req, dump_abort  start / terminate requests
//   rf_addr, rf_data      register-file read port A (asynchronous read)
//   dump_valid/ready      stream handshake
//   dump_data/idx/last    streamed register value, its index, last-beat flag
//   busy, stall_core      engine active; read-port mux select / pipeline freeze
//   done                  one-cycle pulse on normal completion
interface ama_riscv_reg_dump_if;
  logic        dump_req;
  logic        dump_abort;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [4:0]  dump_idx;
  logic        dump_last;
  logic        busy;
  logic        stall_core;
  logic        done;

  modport master (
    input  dump_req, dump_abort, rf_data, dump_ready,
    output rf_addr, dump_valid, dump_data, dump_idx, dump_last,
           busy, stall_core, done
  );

  modport slave (
    output dump_req, dump_abort, rf_data, dump_ready,
    input  rf_addr, dump_valid, dump_data, dump_idx, dump_last,
           busy, stall_core, done
  );
endinterface

// File: rtl/ama_riscv_reg_dump.sv
// ama_riscv_reg_dump
// Debug register-dump engine. On dump_req it stalls the core, waits
// DRAIN_CYCLES for in-flight write-backs to land, then reads registers
// START_IDX..END_IDX one at a time through register-file read port A and
// streams each value with its index over a valid/ready handshake.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : ama_riscv_reg_dump_if.master (see interface for signal list)
// Parameters:
//   START_IDX    first register dumped (0..31)
//   END_IDX      last register dumped (START_IDX..31)
//   DRAIN_CYCLES stall cycles before the first read (1..15)
module ama_riscv_reg_dump #(
  parameter int START_IDX    = 0,
  parameter int END_IDX      = 31,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  ama_riscv_reg_dump_if.master       bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DRAIN = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [4:0] START_A    = 5'(START_IDX);
  localparam logic [4:0] END_A      = 5'(END_IDX);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  logic [2:0]  state;
  logic [4:0]  idx;
  logic [3:0]  drain_cnt;
  logic [31:0] data_q;
  logic        active;
  logic        handshake;

  assign active    = (state != IDLE);
  assign handshake = (state == SEND) && bus.dump_ready;

  // Control and capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 5'd0;
      drain_cnt <= 4'd0;
      data_q    <= 32'd0;
    end else if (active && bus.dump_abort) begin
      // Abort wins over a same-cycle handshake; that beat is treated as taken.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dump_req) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
            idx       <= START_A;
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) state <= READ;
          else                   drain_cnt <= drain_cnt - 4'd1;
        end
        READ: begin
          data_q <= bus.rf_data;
          state  <= SEND;
        end
        SEND: begin
          if (handshake) begin
            // Termination is by equality, so the 5-bit index never wraps.
            if (idx == END_A) begin
              state <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only
  assign bus.busy       = active;
  assign bus.stall_core = active;
  assign bus.rf_addr    = active ? idx : 5'd0;
  assign bus.dump_valid = (state == SEND);
  assign bus.dump_data  = data_q;
  assign bus.dump_idx   = idx;
  assign bus.dump_last  = (state == SEND) && (idx == END_A);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_ama_riscv_reg_dump.sv
module tb_ama_riscv_reg_dump;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;

  ama_riscv_reg_dump_if a_if ();
  ama_riscv_reg_dump_if b_if ();

  ama_riscv_reg_dump u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  ama_riscv_reg_dump #(
    .START_IDX    (5),
    .END_IDX      (7),
    .DRAIN_CYCLES (1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  // Register file model: reg k holds 0xA500_0000|k, reg 0 reads 0.
  function automatic logic [31:0] exp_reg(input int k);
    logic [31:0] v;
    v = 32'hA500_0000 | 32'(k);
    return (k == 0) ? 32'd0 : v;
  endfunction

  assign a_if.rf_data = exp_reg(int'(a_if.rf_addr));
  assign b_if.rf_data = exp_reg(int'(b_if.rf_addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; observe at the following falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // dump_req is sampled by the edge that begins cycle 1.
  task automatic start_a();
    a_if.dump_req = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    a_if.dump_req = 1'b0;
  endtask

  task automatic start_b();
    b_if.dump_req = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    b_if.dump_req = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rf_addr"}, 32'(a_if.rf_addr), 32'd0);
    chk({tag, "_valid"},   32'(a_if.dump_valid), 32'd0);
    chk({tag, "_data"},    a_if.dump_data, 32'd0);
    chk({tag, "_idx"},     32'(a_if.dump_idx), 32'd0);
    chk({tag, "_last"},    32'(a_if.dump_last), 32'd0);
    chk({tag, "_busy"},    32'(a_if.busy), 32'd0);
    chk({tag, "_stall"},   32'(a_if.stall_core), 32'd0);
    chk({tag, "_done"},    32'(a_if.done), 32'd0);
  endtask

  int  k;
  int  exp_idx;
  int  beats;
  bit  done_seen;
  bit  held;
  logic [4:0]  held_idx;
  logic [31:0] held_data;
  bit  rdy;
  bit  exp_v;

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    a_if.dump_req   = 1'b0;
    a_if.dump_abort = 1'b0;
    a_if.dump_ready = 1'b0;
    b_if.dump_req   = 1'b0;
    b_if.dump_abort = 1'b0;
    b_if.dump_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full default dump, ready high; a second dump_req at cycle 20 is ignored.
    a_if.dump_ready = 1'b1;
    start_a();
    for (int c = 1; c <= 68; c++) begin
      if (c > 1) step();
      exp_v = (c >= 4) && (c <= 66) && (c % 2 == 0);
      chk("t1_valid", 32'(a_if.dump_valid), 32'(exp_v));
      if (exp_v) begin
        k = (c - 4) / 2;
        chk("t1_idx",  32'(a_if.dump_idx), 32'(k));
        chk("t1_data", a_if.dump_data, exp_reg(k));
        chk("t1_last", 32'(a_if.dump_last), 32'(k == 31));
      end
      if ((c >= 3) && (c <= 65) && (c % 2 == 1))
        chk("t1_rf_addr", 32'(a_if.rf_addr), 32'((c - 3) / 2));
      chk("t1_done",  32'(a_if.done), 32'(c == 67));
      chk("t1_busy",  32'(a_if.busy), 32'(c <= 67));
      chk("t1_stall", 32'(a_if.stall_core), 32'(c <= 67));
      a_if.dump_req = (c == 20);
    end
    a_if.dump_req = 1'b0;
    step();
    chk("t1_idle_busy", 32'(a_if.busy), 32'd0);

    // Ready toggling 1/0: no lost or duplicated beats, held words stable.
    exp_idx   = 0;
    beats     = 0;
    done_seen = 1'b0;
    held      = 1'b0;
    held_idx  = 5'd0;
    held_data = 32'd0;
    a_if.dump_ready = 1'b0;
    start_a();
    for (int c = 1; c <= 200 && !done_seen; c++) begin
      if (c > 1) step();
      if (a_if.done) done_seen = 1'b1;
      chk("t2_stall", 32'(a_if.stall_core), 32'd1);
      if (held) begin
        chk("t2_hold_valid", 32'(a_if.dump_valid), 32'd1);
        chk("t2_hold_idx",   32'(a_if.dump_idx), 32'(held_idx));
        chk("t2_hold_data",  a_if.dump_data, held_data);
      end
      if (a_if.dump_valid) begin
        chk("t2_idx",  32'(a_if.dump_idx), 32'(exp_idx));
        chk("t2_data", a_if.dump_data, exp_reg(exp_idx));
        chk("t2_last", 32'(a_if.dump_last), 32'(exp_idx == 31));
      end
      rdy = (c % 2 == 1);
      a_if.dump_ready = rdy;
      held      = a_if.dump_valid && !rdy;
      held_idx  = a_if.dump_idx;
      held_data = a_if.dump_data;
      if (a_if.dump_valid && rdy) begin
        beats++;
        exp_idx++;
      end
    end
    chk("t2_beats", 32'(beats), 32'd32);
    chk("t2_done_seen", 32'(done_seen), 32'd1);
    a_if.dump_ready = 1'b1;
    step();
    chk("t2_idle_busy", 32'(a_if.busy), 32'd0);

    // START_IDX=5, END_IDX=7, DRAIN_CYCLES=1: beats at 3,5,7, done at 8.
    b_if.dump_ready = 1'b1;
    start_b();
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) step();
      exp_v = (c == 3) || (c == 5) || (c == 7);
      chk("t3_valid", 32'(b_if.dump_valid), 32'(exp_v));
      if (exp_v) begin
        k = 5 + (c - 3) / 2;
        chk("t3_idx",  32'(b_if.dump_idx), 32'(k));
        chk("t3_data", b_if.dump_data, exp_reg(k));
        chk("t3_last", 32'(b_if.dump_last), 32'(k == 7));
      end
      chk("t3_done", 32'(b_if.done), 32'(c == 8));
      chk("t3_busy", 32'(b_if.busy), 32'(c <= 8));
    end

    // Abort during SEND of idx 10 with ready high.
    a_if.dump_ready = 1'b1;
    start_a();
    for (int c = 2; c <= 24; c++) step();
    chk("t4_pre_valid", 32'(a_if.dump_valid), 32'd1);
    chk("t4_pre_idx",   32'(a_if.dump_idx), 32'd10);
    a_if.dump_abort = 1'b1;
    step();
    a_if.dump_abort = 1'b0;
    chk("t4_valid",   32'(a_if.dump_valid), 32'd0);
    chk("t4_busy",    32'(a_if.busy), 32'd0);
    chk("t4_stall",   32'(a_if.stall_core), 32'd0);
    chk("t4_done",    32'(a_if.done), 32'd0);
    chk("t4_rf_addr", 32'(a_if.rf_addr), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t4_no_done", 32'(a_if.done), 32'd0);
      chk("t4_idle",    32'(a_if.busy), 32'd0);
    end
    start_a();
    for (int c = 2; c <= 4; c++) step();
    chk("t4_restart_valid", 32'(a_if.dump_valid), 32'd1);
    chk("t4_restart_idx",   32'(a_if.dump_idx), 32'd0);
    chk("t4_restart_data",  a_if.dump_data, 32'd0);

    // Asynchronous reset mid-SEND (idx 1).
    step();
    step();
    chk("t5_pre_valid", 32'(a_if.dump_valid), 32'd1);
    chk("t5_pre_data",  a_if.dump_data, exp_reg(1));
    #1 rst = 1'b1;
    #1;
    chk_reset("t5");
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("t5_after_busy", 32'(a_if.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
